// File: rtl/fifo_sync_ctrl_pkg.sv
// Shared constants and helpers for the synchronous FIFO controller.
// Read-mode encodings, default geometry and the threshold range rule.
package fifo_sync_ctrl_pkg;

    localparam int FIFO_MODE_STD     = 0;
    localparam int FIFO_MODE_FWFT    = 1;
    localparam int FIFO_DEF_DATASIZE = 8;
    localparam int FIFO_DEF_ADDRSIZE = 4;

    typedef enum logic {
        MODE_STD  = 1'b0,
        MODE_FWFT = 1'b1
    } fifo_mode_e;

    // Legal: 1 <= afull <= depth and 0 <= aempty < depth.
    function automatic bit fifo_th_ok(input int addrsize, input int afull, input int aempty);
        int depth;
        depth = 1 << addrsize;
        return (afull >= 1) && (afull <= depth) && (aempty >= 0) && (aempty < depth);
    endfunction

    function automatic bit fifo_mode_ok(input int mode);
        return (mode == FIFO_MODE_STD) || (mode == FIFO_MODE_FWFT);
    endfunction

endpackage

// File: rtl/fifo_sync_ctrl_if.sv
// Producer/consumer handshake bundle for fifo_sync_ctrl.
// master = the pipeline side, slave = the FIFO.
interface fifo_sync_ctrl_if #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
);
    logic [DATASIZE-1:0] wdata;
    logic                winc;
    logic                wfull;
    logic                wafull;
    logic                rinc;
    logic [DATASIZE-1:0] rdata;
    logic                rempty;
    logic                raempty;
    logic [ADDRSIZE:0]   count;
    logic                ovf;
    logic                udf;

    modport master (
        output wdata, winc, rinc,
        input  wfull, wafull, rdata, rempty, raempty, count, ovf, udf
    );

    modport slave (
        input  wdata, winc, rinc,
        output wfull, wafull, rdata, rempty, raempty, count, ovf, udf
    );
endinterface

// File: rtl/fifo_ram_dp.sv
// DEPTH x DATASIZE dual-port storage: synchronous write, combinational read.
// Contents are deliberately not reset; the controller never exposes unwritten words.
module fifo_ram_dp #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                i_clk,
    input  logic                i_wen,
    input  logic [ADDRSIZE-1:0] i_waddr,
    input  logic [DATASIZE-1:0] i_wdata,
    input  logic [ADDRSIZE-1:0] i_raddr,
    output logic [DATASIZE-1:0] o_rdata
);
    localparam int DEPTH = 1 << ADDRSIZE;

    logic [DATASIZE-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wen) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO control: pointers, occupancy, registered flags, sticky errors,
// and an optional first-word-fall-through output register in front of the RAM.
module fifo_sync_ctrl
    import fifo_sync_ctrl_pkg::*;
#(
    parameter int DATASIZE  = FIFO_DEF_DATASIZE,
    parameter int ADDRSIZE  = FIFO_DEF_ADDRSIZE,
    parameter int FWFT      = FIFO_MODE_STD,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2
) (
    input  logic            clk,
    input  logic            rst,
    fifo_sync_ctrl_if.slave bus
);
    localparam int                DEPTH    = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] C_DEPTH  = (ADDRSIZE+1)'(DEPTH);
    localparam logic [ADDRSIZE:0] C_ONE    = (ADDRSIZE+1)'(1);
    localparam logic [ADDRSIZE:0] C_AFULL  = (ADDRSIZE+1)'(AFULL_TH);
    localparam logic [ADDRSIZE:0] C_AEMPTY = (ADDRSIZE+1)'(AEMPTY_TH);
    localparam fifo_mode_e        C_MODE   = (FWFT == FIFO_MODE_FWFT) ? MODE_FWFT : MODE_STD;

    if (!fifo_th_ok(ADDRSIZE, AFULL_TH, AEMPTY_TH)) begin : g_th_err
        $error("fifo_sync_ctrl: AFULL_TH/AEMPTY_TH out of range for DEPTH");
    end
    if (!fifo_mode_ok(FWFT)) begin : g_mode_err
        $error("fifo_sync_ctrl: FWFT must be 0 or 1");
    end

    logic [ADDRSIZE:0]   r_wptr;
    logic [ADDRSIZE:0]   r_rptr;
    logic [ADDRSIZE:0]   r_count;
    logic                r_wfull;
    logic                r_wafull;
    logic                r_rempty;
    logic                r_raempty;
    logic                r_ovf;
    logic                r_udf;
    logic [DATASIZE-1:0] r_rdata;
    logic                r_ovalid;

    logic                w_wr_acc;
    logic                w_rd_acc;
    logic [ADDRSIZE:0]   w_count_nxt;
    logic [ADDRSIZE:0]   w_ram_cnt;
    logic                w_load;
    logic                w_rptr_adv;
    logic [DATASIZE-1:0] w_ram_rdata;

    fifo_ram_dp #(
        .DATASIZE (DATASIZE),
        .ADDRSIZE (ADDRSIZE)
    ) u_ram (
        .i_clk   (clk),
        .i_wen   (w_wr_acc),
        .i_waddr (r_wptr[ADDRSIZE-1:0]),
        .i_wdata (bus.wdata),
        .i_raddr (r_rptr[ADDRSIZE-1:0]),
        .o_rdata (w_ram_rdata)
    );

    assign w_wr_acc  = bus.winc && !r_wfull;
    assign w_rd_acc  = bus.rinc && !r_rempty;
    assign w_ram_cnt = r_wptr - r_rptr;

    // In FWFT mode the RAM feeds the output register; a pop refills it on the same edge.
    assign w_load     = (C_MODE == MODE_FWFT) && (!r_ovalid || w_rd_acc) && (w_ram_cnt != '0);
    assign w_rptr_adv = (C_MODE == MODE_FWFT) ? w_load : w_rd_acc;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + C_ONE;
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_nxt = r_count - C_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_wfull   <= 1'b0;
            r_wafull  <= 1'b0;
            r_rempty  <= 1'b1;
            r_raempty <= 1'b1;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
            r_rdata   <= '0;
            r_ovalid  <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + C_ONE;
            end
            if (w_rptr_adv) begin
                r_rptr <= r_rptr + C_ONE;
            end
            r_count   <= w_count_nxt;
            r_wfull   <= (w_count_nxt == C_DEPTH);
            r_wafull  <= (w_count_nxt >= C_AFULL);
            r_raempty <= (w_count_nxt <= C_AEMPTY);
            r_ovf     <= r_ovf | (bus.winc & r_wfull);
            r_udf     <= r_udf | (bus.rinc & r_rempty);

            if (C_MODE == MODE_FWFT) begin
                if (w_load) begin
                    r_rdata  <= w_ram_rdata;
                    r_ovalid <= 1'b1;
                end else if (w_rd_acc) begin
                    r_ovalid <= 1'b0;
                end
                // Visible after this edge if refilled, or held and not popped.
                r_rempty <= !w_load && !(r_ovalid && !w_rd_acc);
            end else begin
                if (w_rd_acc) begin
                    r_rdata <= w_ram_rdata;
                end
                r_rempty <= (w_count_nxt == '0);
            end
        end
    end

    assign bus.wfull   = r_wfull;
    assign bus.wafull  = r_wafull;
    assign bus.rempty  = r_rempty;
    assign bus.raempty = r_raempty;
    assign bus.count   = r_count;
    assign bus.ovf     = r_ovf;
    assign bus.udf     = r_udf;
    assign bus.rdata   = r_rdata;

endmodule
